dmem_byte_ctrl: RTL

- Data-memory responder on the far side of the MEM stage's load/store request interface.
- Accepts one load or store of byte, half or word width per request.
- Serialises the access into byte-wide cycles on an 8-bit synchronous RAM port, little-endian, and returns sign- or zero-extended load data.
- Drives a combinational stall so the pipeline holds until the response is delivered.

---
 rtl/dmem_byte_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_byte_ctrl.sv
// dmem_byte_ctrl: serialises byte/half/word loads and stores onto an 8-bit synchronous RAM port.
module dmem_byte_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);
    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, RESP} state_t;
    state_t state, state_nx;
    logic              we_q, uns_q;
    logic [1:0]        size_q, i, last, ip;
    logic [ADDR_W-1:0] addr_q, cur_addr;
    logic [31:0]       wdata_q, asm_q, rdata_q, full, ext;

    assign last     = size_q == 2'd0 ? 2'd0 : size_q == 2'd1 ? 2'd1 : 2'd3;
    assign ip       = i - 2'd1;
    assign cur_addr = addr_q + ADDR_W'(i);
    // Final byte arrives on ram_din in RD_TAIL; merge it before extending.
    assign full     = asm_q | (32'(ram_din) << {last, 3'b000});
    assign ext      = size_q == 2'd0 ? {{24{~uns_q & full[7]}}, full[7:0]} :
                      size_q == 2'd1 ? {{16{~uns_q & full[15]}}, full[15:0]} : full;

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        stall_o    = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_dout   = 8'h00;
        resp_rdata = rdata_q;
        case (state)
            IDLE: begin
                req_ready = !rst;
                stall_o   = !rst && req_valid;
                if (req_valid) state_nx = req_we ? WR : RD;
            end
            RD: begin
                stall_o  = !rst;
                ram_addr = cur_addr;
                if (i == last) state_nx = RD_TAIL;
            end
            RD_TAIL: begin
                stall_o  = !rst;
                state_nx = RESP;
            end
            WR: begin
                stall_o  = !rst;
                ram_wr   = !rst;
                ram_addr = cur_addr;
                ram_dout = wdata_q[{i, 3'b000} +: 8];
                if (i == last) state_nx = RESP;
            end
            RESP: begin
                resp_valid = !rst;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            i       <= 2'd0;
            asm_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    size_q  <= req_size;
                    uns_q   <= req_unsigned;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    i       <= 2'd0;
                    asm_q   <= 32'h0;
                end
                RD: begin
                    if (i != 2'd0) asm_q[{ip, 3'b000} +: 8] <= ram_din;
                    i <= i + 2'd1;
                end
                RD_TAIL: begin
                    asm_q   <= full;
                    rdata_q <= ext;
                end
                WR: begin
                    i <= i + 2'd1;
                    if (i == last) rdata_q <= 32'h0;
                end
                default: ;
            endcase
        end
    end
endmodule
